// File: rtl/histo_link_pkg.sv
// Shared constants and FSM state type for the histogram serial link receiver.
package histo_link_pkg;

  localparam int NUM_BINS = 1024;
  localparam int BIN_W    = $clog2(NUM_BINS);
  localparam int COUNT_W  = 24;
  localparam int TAG_W    = 8;
  localparam int WORD_W   = TAG_W + COUNT_W;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BINS,
    DONE
  } state_e;

endpackage

// File: rtl/histo_frame_receiver_if.sv
// Link pins plus the per-bin record bus; the receiver uses the slave modport.
interface histo_frame_receiver_if #(
  parameter int BIN_W = histo_link_pkg::BIN_W
);
  import histo_link_pkg::*;

  logic                     spi_clk_i;
  logic                     spi_mosi_i;
  logic                     bin_valid;
  logic [BIN_W-1:0]         bin_index;
  logic [COUNT_W-1:0]       bin_count;
  logic                     frame_done;
  logic [TAG_W-1:0]         frame_id;
  logic [COUNT_W+BIN_W-1:0] frame_sum;
  logic                     frame_id_err;
  logic                     spacer_err;
  logic                     trunc_err;
  logic                     busy;

  modport slave (
    input  spi_clk_i, spi_mosi_i,
    output bin_valid, bin_index, bin_count, frame_done, frame_id, frame_sum,
           frame_id_err, spacer_err, trunc_err, busy
  );

  modport master (
    output spi_clk_i, spi_mosi_i,
    input  bin_valid, bin_index, bin_count, frame_done, frame_id, frame_sum,
           frame_id_err, spacer_err, trunc_err, busy
  );

endinterface

// File: rtl/spi_rx_shift.sv
// Synchronises SCLK/MOSI into clk, detects SCLK rising edges and assembles
// 32-bit MSB-first words with a one-cycle word strobe.
module spi_rx_shift
  import histo_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_clear,
  output logic              o_edge,
  output logic              o_word_strobe,
  output logic [WORD_W-1:0] o_word
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [WORD_W-1:0]      r_shift;
  logic                   r_word_strobe;
  logic                   w_edge;

  assign w_edge = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values together; blocking assignments would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync   <= '0;
      r_mosi_sync   <= '0;
      r_sclk_prev   <= 1'b0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_word_strobe <= 1'b0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_prev   <= r_sclk_sync[SYNC_STAGES-1];
      r_word_strobe <= w_edge && (r_bit_cnt == CNT_W'(WORD_W - 1));
      if (w_edge) begin
        r_shift   <= {r_shift[WORD_W-2:0], r_mosi_sync[SYNC_STAGES-1]};
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end else if (i_clear) begin
        r_bit_cnt <= '0;
      end
    end
  end

  assign o_edge        = w_edge;
  assign o_word_strobe = r_word_strobe;
  assign o_word        = r_shift;

endmodule

// File: rtl/histo_frame_receiver.sv
// Re-frames link words into per-bin records, checks tag/id/truncation and
// accumulates the per-frame pixel total.
module histo_frame_receiver #(
  parameter int NUM_BINS     = histo_link_pkg::NUM_BINS,
  parameter int IDLE_TIMEOUT = 256,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  histo_frame_receiver_if.slave  link
);
  import histo_link_pkg::*;

  localparam int IDX_W = $clog2(NUM_BINS);
  localparam int SUM_W = COUNT_W + IDX_W;
  localparam int TMR_W = $clog2(IDLE_TIMEOUT);

  state_e             r_state, w_next;
  logic [IDX_W-1:0]   r_word_no;
  logic [TMR_W-1:0]   r_timer;
  logic [SUM_W-1:0]   r_acc, r_frame_sum;
  logic [TAG_W-1:0]   r_frame_id, r_prev_id;
  logic               r_first;
  logic               r_bin_valid, r_frame_done, r_id_err, r_spacer_err, r_trunc_err;
  logic [IDX_W-1:0]   r_bin_index;
  logic [COUNT_W-1:0] r_bin_count;

  logic               w_edge, w_word_strobe, w_timeout, w_in_frame;
  logic [WORD_W-1:0]  w_word;
  logic [TAG_W-1:0]   w_tag;
  logic [COUNT_W-1:0] w_count;
  logic               w_bin_valid, w_frame_done, w_id_err, w_spacer_err;
  logic [IDX_W-1:0]   w_bin_index;
  logic [COUNT_W-1:0] w_bin_count;

  spi_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_sclk        (link.spi_clk_i),
    .i_mosi        (link.spi_mosi_i),
    .i_clear       (w_timeout),
    .o_edge        (w_edge),
    .o_word_strobe (w_word_strobe),
    .o_word        (w_word)
  );

  assign w_tag      = w_word[WORD_W-1 -: TAG_W];
  assign w_count    = w_word[COUNT_W-1:0];
  assign w_in_frame = (r_state == HEADER) || (r_state == BINS);
  // An SCLK edge in the expiry cycle keeps the frame alive.
  assign w_timeout  = w_in_frame && !w_edge && (r_timer == TMR_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: each comb output gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_edge) w_next = HEADER;
      HEADER:  if (w_timeout) w_next = IDLE;
               else if (w_word_strobe) w_next = BINS;
      BINS:    if (w_timeout) w_next = IDLE;
               else if (w_word_strobe && (r_word_no == IDX_W'(NUM_BINS - 1))) w_next = DONE;
      DONE:    w_next = w_edge ? HEADER : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bin_valid  = 1'b0;
    w_bin_index  = r_bin_index;
    w_bin_count  = r_bin_count;
    w_spacer_err = 1'b0;
    w_frame_done = 1'b0;
    w_id_err     = 1'b0;
    unique case (r_state)
      HEADER: if (w_word_strobe) begin
        w_bin_valid = 1'b1;
        w_bin_index = IDX_W'(NUM_BINS - 1);
        w_bin_count = w_count;
      end
      BINS: if (w_word_strobe) begin
        w_bin_valid  = 1'b1;
        w_bin_index  = r_word_no - IDX_W'(1);
        w_bin_count  = w_count;
        w_spacer_err = (w_tag != '0);
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_id_err     = !r_first && (r_frame_id != r_prev_id + TAG_W'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer      <= '0;
      r_word_no    <= '0;
      r_acc        <= '0;
      r_frame_sum  <= '0;
      r_frame_id   <= '0;
      r_prev_id    <= '0;
      r_first      <= 1'b1;
      r_bin_valid  <= 1'b0;
      r_bin_index  <= '0;
      r_bin_count  <= '0;
      r_spacer_err <= 1'b0;
      r_frame_done <= 1'b0;
      r_id_err     <= 1'b0;
      r_trunc_err  <= 1'b0;
    end else begin
      r_bin_valid  <= w_bin_valid;
      r_bin_index  <= w_bin_index;
      r_bin_count  <= w_bin_count;
      r_spacer_err <= w_spacer_err;
      r_frame_done <= w_frame_done;
      r_id_err     <= w_id_err;
      r_trunc_err  <= w_timeout;

      if (w_edge || !w_in_frame) r_timer <= '0;
      else if (!w_timeout)       r_timer <= r_timer + TMR_W'(1);

      if (w_timeout) begin
        // Partial frame is dropped; the next complete frame restarts the id check.
        r_acc     <= '0;
        r_word_no <= '0;
        r_first   <= 1'b1;
      end else if (r_state == HEADER && w_word_strobe) begin
        r_frame_id <= w_tag;
        r_acc      <= SUM_W'(w_count);
        r_word_no  <= IDX_W'(1);
      end else if (r_state == BINS && w_word_strobe) begin
        r_acc     <= r_acc + SUM_W'(w_count);
        r_word_no <= r_word_no + IDX_W'(1);
      end else if (r_state == DONE) begin
        r_frame_sum <= r_acc;
        r_prev_id   <= r_frame_id;
        r_first     <= 1'b0;
      end
    end
  end

  assign link.bin_valid    = r_bin_valid;
  assign link.bin_index    = r_bin_index;
  assign link.bin_count    = r_bin_count;
  assign link.spacer_err   = r_spacer_err;
  assign link.frame_done   = r_frame_done;
  assign link.frame_id     = r_frame_id;
  assign link.frame_sum    = r_frame_sum;
  assign link.frame_id_err = r_id_err;
  assign link.trunc_err    = r_trunc_err;
  assign link.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_histo_frame_receiver.sv
// Scoreboard bench for histo_frame_receiver with a 16-bin frame so full frames stay short.
module tb_histo_frame_receiver;
  import histo_link_pkg::*;

  localparam int NB  = 16;
  localparam int IW  = 4;
  localparam int TMO = 256;

  typedef enum {EV_BIN, EV_DONE, EV_TRUNC} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       idx;
    int       cnt;
    bit       flag;
    longint   sum;
    int       id;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic clk   = 1'b0;
  logic reset_n;
  int   sp_at  = -1;
  logic [7:0] sp_tag = 8'h00;
  bit   jitter = 1'b0;

  histo_frame_receiver_if #(.BIN_W(IW)) link ();

  histo_frame_receiver #(
    .NUM_BINS     (NB),
    .IDLE_TIMEOUT (TMO),
    .SYNC_STAGES  (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .link    (link)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] bin_cnt(input int mode, input int k);
    return (mode != 0) ? 24'hFFFFFF : 24'(k + 1);
  endfunction

  function automatic logic [31:0] frame_word(input logic [7:0] id, input int mode, input int w);
    if (w == 0) return {id, bin_cnt(mode, NB - 1)};
    return {((w == sp_at) ? sp_tag : 8'h00), bin_cnt(mode, w - 1)};
  endfunction

  task automatic half_period();
    if (jitter) #(20 + $urandom_range(0, 7));
    else #20;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int b = 31; b > 31 - nbits; b--) begin
      link.spi_mosi_i = w[b];
      half_period();
      link.spi_clk_i = 1'b1;
      half_period();
      link.spi_clk_i = 1'b0;
    end
  endtask

  task automatic expect_words(input logic [7:0] id, input int mode, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [31:0] word;
      ev_t e;
      word   = frame_word(id, mode, w);
      e.kind = EV_BIN;
      e.idx  = (w == 0) ? NB - 1 : w - 1;
      e.cnt  = int'(word[23:0]);
      e.flag = (w != 0) && (word[31:24] != 8'h00);
      e.sum  = 0;
      e.id   = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_other(input ev_kind_e kind, input longint sum, input int id, input bit err);
    ev_t e;
    e.kind = kind;
    e.idx  = 0;
    e.cnt  = 0;
    e.flag = err;
    e.sum  = sum;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] id, input int mode, input longint sum, input bit err);
    expect_words(id, mode, NB);
    expect_other(EV_DONE, sum, int'(id), err);
    for (int w = 0; w < NB; w++) send_word(frame_word(id, mode, w), 32);
    repeat (8) @(negedge clk);
  endtask

  // Monitor: pops one expectation per output strobe.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (link.bin_valid || link.frame_done || link.trunc_err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {link.bin_valid, link.frame_done, link.trunc_err}, 0);
        end else begin
          e = exp_q.pop_front();
          case (e.kind)
            EV_BIN: begin
              check($sformatf("bin_valid[%0d]", e.idx), link.bin_valid, 1);
              check($sformatf("bin_index[%0d]", e.idx), link.bin_index, e.idx);
              check($sformatf("bin_count[%0d]", e.idx), link.bin_count, e.cnt);
              check($sformatf("spacer_err[%0d]", e.idx), link.spacer_err, e.flag);
            end
            EV_DONE: begin
              check("frame_done", link.frame_done, 1);
              check("frame_sum", link.frame_sum, e.sum);
              check("frame_id", link.frame_id, e.id);
              check("frame_id_err", link.frame_id_err, e.flag);
            end
            default: begin
              check("trunc_err", link.trunc_err, 1);
              check("trunc_no_done", link.frame_done, 0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    link.spi_clk_i  = 1'b0;
    link.spi_mosi_i = 1'b0;
    reset_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bin_valid", link.bin_valid, 0);
    check("rst_bin_index", link.bin_index, 0);
    check("rst_bin_count", link.bin_count, 0);
    check("rst_frame_done", link.frame_done, 0);
    check("rst_frame_id", link.frame_id, 0);
    check("rst_frame_sum", link.frame_sum, 0);
    check("rst_errs", {link.frame_id_err, link.spacer_err, link.trunc_err}, 0);
    check("rst_busy", link.busy, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // One clean frame: counts k+1, sum 1+..+16 = 136.
    send_frame(8'h05, 0, 136, 1'b0);
    check("t1_busy_idle", link.busy, 0);
    check("t1_frame_id_held", link.frame_id, 8'h05);

    // Id sequence: 05->07 error, 07->FF error, FF->00 wraps cleanly.
    send_frame(8'h07, 0, 136, 1'b1);
    send_frame(8'hFF, 0, 136, 1'b1);
    send_frame(8'h00, 0, 136, 1'b0);

    // Truncation after word 5.
    expect_words(8'h20, 0, 6);
    expect_other(EV_TRUNC, 0, 0, 1'b0);
    for (int w = 0; w < 6; w++) send_word(frame_word(8'h20, 0, w), 32);
    repeat (20) @(negedge clk);
    check("t3_busy_open", link.busy, 1);
    repeat (TMO + 10) @(negedge clk);
    check("t3_busy_after_trunc", link.busy, 0);
    check("t3_sum_kept", link.frame_sum, 136);
    check("t3_id_latched", link.frame_id, 8'h20);
    send_frame(8'h50, 0, 136, 1'b0);

    // Nonzero tag on word 7 flags the bin 6 record only.
    sp_at  = 7;
    sp_tag = 8'h3C;
    send_frame(8'h51, 0, 136, 1'b0);
    sp_at  = -1;

    // Reset in the middle of word 10.
    expect_words(8'h52, 0, 10);
    for (int w = 0; w < 10; w++) send_word(frame_word(8'h52, 0, w), 32);
    send_word(frame_word(8'h52, 0, 10), 13);
    check("t5_busy_before_rst", link.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_frame_id", link.frame_id, 0);
    check("t5_rst_frame_sum", link.frame_sum, 0);
    check("t5_rst_busy", link.busy, 0);
    check("t5_rst_strobes", {link.bin_valid, link.frame_done, link.trunc_err, link.spacer_err}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h90, 0, 136, 1'b0);

    // All-ones counts with jittered SCLK: 16 * 0xFFFFFF.
    jitter = 1'b1;
    send_frame(8'h91, 1, 64'd268435440, 1'b0);
    jitter = 1'b0;

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
